// File: rtl/cmp_sort_pkg.sv
// Shared encodings and widths for the block sorter and its comparator.
package cmp_sort_pkg;
  localparam int WORD_W     = 4;
  localparam int SWAP_CNT_W = 8;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator of f against s; purely combinational, no flow control.
module comparator
  import cmp_sort_pkg::*;
(
  input  logic [WORD_W-1:0] f,
  input  logic [WORD_W-1:0] s,
  output logic              gt,
  output logic              lt,
  output logic              eq
);
  assign gt = (f > s);
  assign lt = (f < s);
  assign eq = (f == s);
endmodule

// File: rtl/compare_sort_ctrl.sv
// Loads DEPTH words, bubble-sorts them one compare per clock, then streams them out.
// Sort takes DEPTH-1 .. DEPTH*(DEPTH-1)/2 cycles; load and drain stall on valid/ready, never overlap.
module compare_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST      = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PASS_LAST = PTR_W'(DEPTH - 2);

  logic [1:0]            state_q, state_d;
  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [WORD_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      i_q, i_d;
  logic [PTR_W-1:0]      pass_q, pass_d;
  logic                  swapped_q, swapped_d;
  logic [SWAP_CNT_W-1:0] swap_count_q, swap_count_d;
  logic                  done_q, done_d;

  logic [PTR_W-1:0] i_nxt;
  logic [PTR_W-1:0] i_last;
  logic             cmp_gt, cmp_lt, cmp_eq;
  logic             do_swap;
  logic             swapped_now;

  assign i_nxt  = i_q + 1'b1;
  assign i_last = PASS_LAST - pass_q;

  comparator u_cmp (
    .f  (mem_q[i_q]),
    .s  (mem_q[i_nxt]),
    .gt (cmp_gt),
    .lt (cmp_lt),
    .eq (cmp_eq)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign do_swap = (state_q == ST_SORT) && !cmp_eq && (DESCEND ? cmp_lt : cmp_gt);

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    i_d          = i_q;
    pass_d       = pass_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;
    done_d       = 1'b0;
    swapped_now  = swapped_q | do_swap;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[wr_ptr_q] = in_data;
          if (wr_ptr_q == '0) swap_count_d = '0;
          if (wr_ptr_q == LAST) begin
            state_d   = ST_SORT;
            wr_ptr_d  = '0;
            i_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      ST_SORT: begin
        if (do_swap) begin
          mem_d[i_q]   = mem_q[i_nxt];
          mem_d[i_nxt] = mem_q[i_q];
          swap_count_d = sat_inc(swap_count_q);
        end
        // A clean pass, or the final one-compare pass, means the block is ordered.
        if (i_q == i_last) begin
          i_d       = '0;
          swapped_d = 1'b0;
          if (!swapped_now || pass_q == PASS_LAST) begin
            state_d = ST_DRAIN;
            pass_d  = '0;
            done_d  = 1'b1;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          i_d       = i_nxt;
          swapped_d = swapped_now;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST) begin
            state_d  = ST_LOAD;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      i_q          <= '0;
      pass_q       <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
      done_q       <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      i_q          <= i_d;
      pass_q       <= pass_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q == ST_DRAIN);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (state_q != ST_LOAD);
  assign done       = done_q;
  assign swap_count = swap_count_q;
endmodule
